// File: rtl/afifo_rd_stream_if.sv
// Interface bundle for the read-side FIFO stream converter. It groups the FIFO
// read port with the downstream valid/ready stream.
interface afifo_rd_stream_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  fifo_empty_i;
  logic [DATA_WIDTH-1:0] fifo_data_i;
  logic                  fifo_re_o;
  logic                  m_valid_o;
  logic                  m_ready_i;
  logic [DATA_WIDTH-1:0] m_data_o;

  // master: the converter itself; slave: the FIFO/downstream environment
  modport master (
    input  fifo_empty_i,
    input  fifo_data_i,
    input  m_ready_i,
    output fifo_re_o,
    output m_valid_o,
    output m_data_o
  );

  modport slave (
    output fifo_empty_i,
    output fifo_data_i,
    output m_ready_i,
    input  fifo_re_o,
    input  m_valid_o,
    input  m_data_o
  );
endinterface

// File: rtl/afifo_rd_stream.sv
// Read-domain consumer of an async FIFO. It turns the empty/read-enable port into a
// valid/ready stream, using a small skid buffer that absorbs the 1-cycle read latency.
module afifo_rd_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int SKID_DEPTH = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk_r,
  input  logic                 arst,
  afifo_rd_stream_if.master    bus,
  input  logic                 flush_i,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 busy_o
);
  localparam int PW = $clog2(SKID_DEPTH);
  localparam int OW = $clog2(SKID_DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_buf [SKID_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [OW-1:0]         r_occ;
  logic                  r_inflight;
  logic [CNT_WIDTH-1:0]  r_count;

  logic [PW-1:0]         w_wr_ptr_next;
  logic [PW-1:0]         w_rd_ptr_next;
  logic [OW-1:0]         w_occ_next;
  logic [OW:0]           w_pending;
  logic                  w_valid;
  logic                  w_pop;
  logic                  w_capture;
  logic                  w_room;
  logic                  w_re;

  assign w_valid   = (r_occ != '0);
  assign w_pop     = w_valid && bus.m_ready_i;
  assign w_capture = r_inflight && !flush_i;

  // Slots committed after this cycle: held words plus the returning read, minus the pop.
  // Issuing only when this leaves a free slot means a returning word can never overflow.
  assign w_pending = {1'b0, r_occ} + {{OW{1'b0}}, r_inflight} - {{OW{1'b0}}, w_pop};
  assign w_room    = (w_pending < (OW + 1)'(SKID_DEPTH));
  assign w_re      = !arst && !bus.fifo_empty_i && !flush_i && w_room;

  always_comb begin
    w_wr_ptr_next = r_wr_ptr;
    w_rd_ptr_next = r_rd_ptr;
    w_occ_next    = r_occ;
    if (w_capture) begin
      w_wr_ptr_next = (r_wr_ptr == PW'(SKID_DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
    end
    if (w_pop) begin
      w_rd_ptr_next = (r_rd_ptr == PW'(SKID_DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
    end
    case ({w_capture, w_pop})
      2'b10:   w_occ_next = r_occ + OW'(1);
      2'b01:   w_occ_next = r_occ - OW'(1);
      default: w_occ_next = r_occ;
    endcase
    if (flush_i) begin
      w_wr_ptr_next = '0;
      w_rd_ptr_next = '0;
      w_occ_next    = '0;
    end
  end

  always_ff @(posedge clk_r or posedge arst) begin
    if (arst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_inflight <= 1'b0;
      r_count    <= '0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_next;
      r_rd_ptr   <= w_rd_ptr_next;
      r_occ      <= w_occ_next;
      r_inflight <= w_re;
      // A handshake that coincides with a flush is not counted as a delivery.
      if (w_pop && !flush_i) begin
        r_count <= r_count + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_r) begin
    if (w_capture) begin
      r_buf[r_wr_ptr] <= bus.fifo_data_i;
    end
  end

  assign bus.fifo_re_o = w_re;
  assign bus.m_valid_o = w_valid;
  assign bus.m_data_o  = w_valid ? r_buf[r_rd_ptr] : '0;
  assign count_o       = r_count;
  assign busy_o        = w_valid || r_inflight;
endmodule

// File: tb/tb_afifo_rd_stream.sv
// Directed bench for afifo_rd_stream: a queue-based FIFO model feeds the DUT, and a
// scoreboard checks every delivered word in order.
module tb_afifo_rd_stream;
  localparam int DW = 32;

  logic          clk_r   = 1'b0;
  logic          arst    = 1'b1;
  logic          flush_i = 1'b0;
  logic [15:0]   count_o;
  logic          busy_o;

  afifo_rd_stream_if #(.DATA_WIDTH(DW)) bus ();

  afifo_rd_stream #(
    .DATA_WIDTH(DW),
    .SKID_DEPTH(2),
    .CNT_WIDTH (16)
  ) dut (
    .clk_r  (clk_r),
    .arst   (arst),
    .bus    (bus),
    .flush_i(flush_i),
    .count_o(count_o),
    .busy_o (busy_o)
  );

  always #5 clk_r = ~clk_r;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            checks    = 0;
  int            errors    = 0;
  int            rd_total  = 0;
  int            del_total = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // FIFO model: data returns the cycle after a read; empty reflects the queue per edge.
  always @(posedge clk_r or posedge arst) begin
    if (arst) begin
      fifo_q.delete();
      bus.fifo_empty_i <= 1'b1;
      bus.fifo_data_i  <= '0;
      rd_total         <= 0;
    end else begin
      if (bus.fifo_re_o === 1'b1) begin
        bus.fifo_data_i <= fifo_q.pop_front();
        rd_total        <= rd_total + 1;
      end
      bus.fifo_empty_i <= (fifo_q.size() == 0);
    end
  end

  // Scoreboard / monitor, sampled mid-cycle.
  always @(negedge clk_r) begin
    logic [DW-1:0] e;
    if (arst || flush_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(bus.m_valid_o), 64'd1);
        check("hold_data", 64'(bus.m_data_o), 64'(prev_data));
      end
      if (bus.m_valid_o && bus.m_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(bus.m_data_o), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("stream_data", 64'(bus.m_data_o), 64'(e));
          del_total++;
        end
      end
      prev_stall = bus.m_valid_o && !bus.m_ready_i;
      prev_data  = bus.m_data_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_r);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] v, input bit expect_out);
    fifo_q.push_back(v);
    if (expect_out) exp_q.push_back(v);
  endtask

  task automatic do_reset();
    arst          = 1'b1;
    flush_i       = 1'b0;
    bus.m_ready_i = 1'b0;
    exp_q.delete();
    del_total = 0;
    tick(2);
    arst = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int max_cycles);
    int n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || bus.m_valid_o) && n < max_cycles) begin
      tick(1);
      n++;
    end
    check({tag, "_drain_in_time"}, 64'(n < max_cycles), 64'd1);
  endtask

  initial begin
    bus.m_ready_i = 1'b0;

    // Reset state
    tick(2);
    check("rst_valid", 64'(bus.m_valid_o), 64'd0);
    check("rst_re", 64'(bus.fifo_re_o), 64'd0);
    check("rst_data", 64'(bus.m_data_o), 64'd0);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);

    // 1: latency and back-to-back delivery
    do_reset();
    bus.m_ready_i = 1'b1;
    push(32'h11, 1'b1);
    push(32'h22, 1'b1);
    push(32'h33, 1'b1);
    tick(1);
    check("t1_re_cycleN", 64'(bus.fifo_re_o), 64'd1);
    check("t1_valid_cycleN", 64'(bus.m_valid_o), 64'd0);
    tick(1);
    check("t1_valid_cycleN1", 64'(bus.m_valid_o), 64'd0);
    tick(1);
    check("t1_valid_cycleN2", 64'(bus.m_valid_o), 64'd1);
    check("t1_first_data", 64'(bus.m_data_o), 64'h11);
    tick(1);
    check("t1_second_data", 64'(bus.m_data_o), 64'h22);
    tick(1);
    check("t1_third_data", 64'(bus.m_data_o), 64'h33);
    wait_drain("t1", 20);
    check("t1_count", 64'(count_o), 64'd3);

    // 2: backpressure limits reads to the buffer depth
    do_reset();
    for (int i = 0; i < 8; i++) push(32'hA0 + 32'(i), 1'b1);
    tick(10);
    check("t2_reads_issued", 64'(rd_total), 64'd2);
    check("t2_valid_held", 64'(bus.m_valid_o), 64'd1);
    check("t2_head_data", 64'(bus.m_data_o), 64'hA0);
    check("t2_re_stalled", 64'(bus.fifo_re_o), 64'd0);
    bus.m_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t2_no_gap", 64'(bus.m_valid_o), 64'd1);
      tick(1);
    end
    check("t2_count", 64'(count_o), 64'd8);
    check("t2_all_delivered", 64'(exp_q.size()), 64'd0);

    // 3: toggling ready with continuous data
    do_reset();
    for (int i = 1; i <= 16; i++) push(32'(i), 1'b1);
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) begin
      bus.m_ready_i = ~bus.m_ready_i;
      tick(1);
      check("t3_occ_bound", 64'((rd_total - del_total) <= 2), 64'd1);
    end
    bus.m_ready_i = 1'b1;
    wait_drain("t3", 20);
    check("t3_count", 64'(count_o), 64'd16);
    check("t3_reads", 64'(rd_total), 64'd16);

    // 4: flush with a read in flight and a coinciding handshake
    do_reset();
    push(32'h55, 1'b0);
    for (int n = 0; n < 10 && !bus.m_valid_o; n++) tick(1);
    check("t4_holds_55", 64'(bus.m_data_o), 64'h55);
    push(32'h66, 1'b0);
    tick(1);
    check("t4_re_before_flush", 64'(bus.fifo_re_o), 64'd1);
    tick(1);
    flush_i       = 1'b1;
    bus.m_ready_i = 1'b1;
    #1;
    check("t4_re_in_flush", 64'(bus.fifo_re_o), 64'd0);
    tick(1);
    flush_i = 1'b0;
    check("t4_valid_after", 64'(bus.m_valid_o), 64'd0);
    check("t4_busy_after", 64'(busy_o), 64'd0);
    check("t4_count_kept", 64'(count_o), 64'd0);
    push(32'h77, 1'b1);
    wait_drain("t4", 20);
    check("t4_count_next", 64'(count_o), 64'd1);

    // 5: counter wrap
    do_reset();
    bus.m_ready_i = 1'b1;
    for (int i = 0; i < 65535; i++) push(32'(i), 1'b1);
    wait_drain("t5", 70000);
    check("t5_count_max", 64'(count_o), 64'hFFFF);
    push(32'hBEEF, 1'b1);
    wait_drain("t5b", 20);
    check("t5_count_wrap", 64'(count_o), 64'd0);

    // 6: asynchronous reset mid-stream with a full buffer
    do_reset();
    bus.m_ready_i = 1'b1;
    push(32'hC1, 1'b1);
    push(32'hC2, 1'b1);
    wait_drain("t6", 20);
    check("t6_count_pre", 64'(count_o), 64'd2);
    bus.m_ready_i = 1'b0;
    for (int i = 3; i <= 6; i++) push(32'hC0 + 32'(i), 1'b0);
    tick(6);
    check("t6_valid_pre", 64'(bus.m_valid_o), 64'd1);
    check("t6_busy_pre", 64'(busy_o), 64'd1);
    #2;
    arst = 1'b1;
    #1;
    check("t6_valid_async", 64'(bus.m_valid_o), 64'd0);
    check("t6_re_async", 64'(bus.fifo_re_o), 64'd0);
    check("t6_count_async", 64'(count_o), 64'd0);
    check("t6_busy_async", 64'(busy_o), 64'd0);
    check("t6_data_async", 64'(bus.m_data_o), 64'd0);
    tick(2);
    arst = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
